// File: rtl/cnn_pkg.sv
// Widths and frame constants shared by all CNN pipeline stages.
// Every stage imports these so that the stages agree on bus sizes.
package cnn_pkg;

  localparam int CNN_FEAT_BW    = 23;
  localparam int CNN_WGT_BW     = 8;
  localparam int CNN_BIAS_BW    = 16;
  localparam int CNN_POOL_BW    = 8;
  localparam int CNN_FRAME_X    = 24;
  localparam int CNN_FRAME_Y    = 24;
  localparam int CNN_POOL_SHIFT = 8;
  localparam int CNN_CO         = 3;

endpackage

// File: rtl/relu_quant.sv
// One-channel ReLU, arithmetic shift and output narrowing.
// Define RELU_MAXPOOL_SAT_EN to saturate instead of truncating.
module relu_quant
  import cnn_pkg::*;
#(
  parameter int I_BW  = CNN_FEAT_BW,
  parameter int O_BW  = CNN_POOL_BW,
  parameter int SHIFT = CNN_POOL_SHIFT
) (
  input  logic [I_BW-1:0] x,
  output logic [O_BW-1:0] q
);

  logic [I_BW-1:0] r;

  // r is never negative, so a logical shift equals the arithmetic one
  assign r = x[I_BW-1] ? '0 : x;

`ifdef RELU_MAXPOOL_SAT_EN
  localparam logic [I_BW-1:0] QMAX = I_BW'({O_BW{1'b1}});

  logic [I_BW-1:0] s;

  assign s = r >> SHIFT;
  assign q = (s > QMAX) ? {O_BW{1'b1}} : s[O_BW-1:0];
`else
  assign q = O_BW'(r >> SHIFT);
`endif

endmodule

// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + quantise + 2x2 max-pool over a raster pixel stream.
// Define RELU_MAXPOOL_SAT_EN to saturate outputs instead of truncating.
module relu_maxpool_stream
  import cnn_pkg::*;
#(
  parameter int CO    = CNN_CO,
  parameter int I_BW  = CNN_FEAT_BW,
  parameter int O_BW  = CNN_POOL_BW,
  parameter int IX    = CNN_FRAME_X,
  parameter int IY    = CNN_FRAME_Y,
  parameter int SHIFT = CNN_POOL_SHIFT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_valid,
  input  logic [CO*I_BW-1:0] i_fmap,
  output logic               o_valid,
  output logic [CO*O_BW-1:0] o_fmap,
  output logic               o_done
);

  localparam int XW = $clog2(IX);
  localparam int YW = $clog2(IY);

  typedef logic [CO-1:0][O_BW-1:0] chv_t;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  chv_t          q_vec;
  chv_t          pair;
  chv_t          h_vec;
  chv_t          pool_vec;
  chv_t          lb_rd;
  chv_t          linebuf [IX/2];

  logic [XW-2:0] lb_idx;
  logic          x_odd;
  logic          y_odd;
  logic          x_last;
  logic          y_last;

  assign lb_idx = x_cnt[XW-1:1];
  assign x_odd  = x_cnt[0];
  assign y_odd  = y_cnt[0];
  assign x_last = (x_cnt == XW'(IX-1));
  assign y_last = (y_cnt == YW'(IY-1));

  for (genvar ch = 0; ch < CO; ch++) begin : g_ch
    relu_quant #(
      .I_BW  (I_BW),
      .O_BW  (O_BW),
      .SHIFT (SHIFT)
    ) u_rq (
      .x (i_fmap[ch*I_BW +: I_BW]),
      .q (q_vec[ch])
    );
  end

  always_comb begin
    h_vec    = '0;
    pool_vec = '0;
    lb_rd    = linebuf[lb_idx];
    for (int ch = 0; ch < CO; ch++) begin
      h_vec[ch] = (q_vec[ch] > pair[ch]) ? q_vec[ch] : pair[ch];
      pool_vec[ch] = (h_vec[ch] > lb_rd[ch]) ? h_vec[ch] : lb_rd[ch];
    end
  end

  // Even rows only stash the horizontal max; odd rows consume it
  always_ff @(posedge clk) begin
    if (i_valid && x_odd && !y_odd)
      linebuf[lb_idx] <= h_vec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (i_valid) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair    <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_fmap  <= '0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      if (i_valid) begin
        unique case (1'b1)
          !x_odd: pair <= q_vec;
          x_odd && y_odd: begin
            o_fmap  <= pool_vec;
            o_valid <= 1'b1;
            o_done  <= x_last && y_last;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench for relu_maxpool_stream (default parameters).
// Expected pooled pixels are queued by the driver, checked by a monitor.
module tb_relu_maxpool_stream;

  localparam int CO   = 3;
  localparam int I_BW = 23;
  localparam int O_BW = 8;
  localparam int IX   = 24;
  localparam int IY   = 24;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               i_valid = 1'b0;
  logic [CO*I_BW-1:0] i_fmap = '0;
  logic               o_valid;
  logic [CO*O_BW-1:0] o_fmap;
  logic               o_done;

  typedef struct packed {
    logic [CO*O_BW-1:0] fmap;
    logic               done;
  } exp_t;

  exp_t               sbq[$];
  int                 checks = 0;
  int                 fails = 0;
  int                 n_out = 0;
  int                 n_done = 0;
  logic [CO*O_BW-1:0] last_exp = '0;
  logic [7:0]         qm [CO][IY][IX];

  relu_maxpool_stream dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .i_fmap  (i_fmap),
    .o_valid (o_valid),
    .o_fmap  (o_fmap),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  // kinds: 0 mixed ramp, 1 all -5, 2 saturation, 3 single max at (5,7)
  function automatic logic [I_BW-1:0] pix(int kind, int ch, int x, int y);
    int v;
    case (kind)
      0: case (ch)
           0: v = (y*24 + x) << 8;
           1: v = ((x*7 + y*3) % 256) << 8;
           default: v = (((x ^ y) & 1) != 0) ? -1000 : (x + y) << 9;
         endcase
      1: v = -5;
      2: case (ch)
           0: v = 32'h10000;
           1: v = 32'h0FFFF;
           default: v = 32'h10100;
         endcase
      default: v = (x == 5 && y == 7) ? 32'h3200 : 0;
    endcase
    return v[I_BW-1:0];
  endfunction

  function automatic logic [7:0] mq(logic [I_BW-1:0] v);
    int s;
    if (v[I_BW-1]) return 8'd0;
    s = int'(v) >> 8;
`ifdef RELU_MAXPOOL_SAT_EN
    if (s > 255) return 8'hff;
`endif
    return s[7:0];
  endfunction

  function automatic logic [7:0] max4(logic [7:0] a, logic [7:0] b,
                                      logic [7:0] c, logic [7:0] d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic idle();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send(int kind, int x, int y);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    for (int ch = 0; ch < CO; ch++) begin
      i_fmap[ch*I_BW +: I_BW] = pix(kind, ch, x, y);
      qm[ch][y][x] = mq(pix(kind, ch, x, y));
    end
    if ((x % 2 == 1) && (y % 2 == 1)) begin
      for (int ch = 0; ch < CO; ch++)
        e.fmap[ch*O_BW +: O_BW] = max4(qm[ch][y-1][x-1], qm[ch][y-1][x],
                                       qm[ch][y][x-1], qm[ch][y][x]);
      e.done = (x == IX-1) && (y == IY-1);
      sbq.push_back(e);
    end
  endtask

  task automatic frame(int kind, bit gaps, int npix);
    int k;
    k = 0;
    for (int y = 0; y < IY; y++)
      for (int x = 0; x < IX; x++) begin
        if (k < npix) begin
          if (gaps)
            for (int g = 0; g < 4 && $urandom_range(1) == 1; g++) idle();
          send(kind, x, y);
        end
        k++;
      end
  endtask

  task automatic check_counts(string name, int o0, int d0, int eo, int ed);
    repeat (4) idle();
    checks++;
    if (n_out - o0 != eo) begin
      fails++;
      $display("FAIL %s_outputs got=%0d exp=%0d", name, n_out - o0, eo);
    end
    checks++;
    if (n_done - d0 != ed) begin
      fails++;
      $display("FAIL %s_done got=%0d exp=%0d", name, n_done - d0, ed);
    end
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_pending got=%0d exp=0", name, sbq.size());
    end
  endtask

  task automatic check_reset_outs(string name);
    checks++;
    if (o_valid !== 1'b0 || o_done !== 1'b0 || o_fmap !== '0) begin
      fails++;
      $display("FAIL %s got=%b/%b/%h exp=0/0/0", name, o_valid, o_done, o_fmap);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      checks++;
      if (o_valid) begin
        n_out++;
        if (o_done) n_done++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out got=%h/%b exp=none", o_fmap, o_done);
        end else begin
          e = sbq.pop_front();
          last_exp = e.fmap;
          if (o_fmap !== e.fmap || o_done !== e.done) begin
            fails++;
            $display("FAIL pool_out got=%h/%b exp=%h/%b",
                     o_fmap, o_done, e.fmap, e.done);
          end
        end
      end else if (o_fmap !== last_exp || o_done !== 1'b0) begin
        fails++;
        $display("FAIL idle_hold got=%h/%b exp=%h/0",
                 o_fmap, o_done, last_exp);
      end
    end
  end

  initial begin
    int o0, d0;
    #2;
    check_reset_outs("reset_init");
    @(negedge clk);
    reset_n = 1'b1;

    o0 = n_out; d0 = n_done;
    frame(0, 1'b0, IX*IY);
    frame(1, 1'b0, IX*IY);
    check_counts("ramp_neg", o0, d0, 288, 2);

    o0 = n_out; d0 = n_done;
    frame(2, 1'b0, IX*IY);
    frame(3, 1'b0, IX*IY);
    check_counts("sat_single", o0, d0, 288, 2);

    o0 = n_out; d0 = n_done;
    frame(0, 1'b1, IX*IY);
    frame(0, 1'b1, IX*IY);
    check_counts("gaps", o0, d0, 288, 2);

    o0 = n_out; d0 = n_done;
    frame(0, 1'b0, 300);
    idle();
    reset_n = 1'b0;
    #1;
    check_reset_outs("reset_mid");
    check_counts("partial", o0, d0, 72, 0);
    sbq.delete();
    last_exp = '0;
    check_reset_outs("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;

    o0 = n_out; d0 = n_done;
    frame(0, 1'b0, IX*IY);
    check_counts("after_reset", o0, d0, 144, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
